// File: rtl/rv_pkg.sv
// Shared RV32I/RV32E decode definitions: opcodes, ALU ops, immediate formats
// and the control portion of the decoded micro-op.
package rv_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SLT   = 4'd6,
        ALU_SLTU  = 4'd7,
        ALU_SRA   = 4'd8,
        ALU_SRL   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_SHAMT,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } fmt_e;

    // PC and immediate are XLEN-wide and carried alongside this struct.
    typedef struct packed {
        alu_op_e    alu_op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       use_imm;
        logic       rf_we;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic       is_auipc;
        logic [2:0] funct3;
        logic       illegal;
    } uop_ctrl_t;

    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Immediate generator: selects the immediate layout for the decoded format
// and sign-extends it to XLEN (shift amounts are zero-extended).
module rv_imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  fmt_e            fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I:     imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_SHAMT: imm32 = {27'b0, instr[24:20]};
            FMT_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:     imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:     imm32 = {instr[31:12], 12'b0};
            FMT_J:     imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:   imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/rv_decode_stage.sv
// Decode stage: full RV32I/RV32E decode into a registered micro-op, with a
// two-entry skid buffer between fetch and execute handshakes.
module rv_decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [3:0]       out_alu_op,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_use_imm,
    output logic             out_rf_we,
    output logic             out_is_load,
    output logic             out_is_store,
    output logic             out_is_branch,
    output logic             out_is_jal,
    output logic             out_is_jalr,
    output logic             out_is_auipc,
    output logic [2:0]       out_funct3,
    output logic             out_illegal,
    output logic [CNT_W-1:0] decode_count
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_FULL
    } occ_e;

    occ_e            state, state_next;
    uop_ctrl_t       dec, main_ctrl, skid_ctrl;
    fmt_e            fmt;
    logic [XLEN-1:0] dec_imm, main_imm, skid_imm, main_pc, skid_pc;
    logic            accept, hs, load_main_in, load_main_skid, load_skid;
    logic            use_rs1, use_rs2, use_rd, bad;

    logic [6:0] opcode, f7;
    logic [4:0] rs1, rs2, rd;
    logic [2:0] f3;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign f3     = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign f7     = in_instr[31:25];

    function automatic logic reg_bad(input logic [4:0] idx);
        return int'(idx) >= NREGS;
    endfunction

    always_comb begin
        dec     = '0;
        fmt     = FMT_R;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        bad     = 1'b0;
        case (opcode)
            OPC_R: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                dec.alu_op = alu_from_funct3(f3);
                if (f7 == F7_ALT) begin
                    if (f3 == 3'b000)      dec.alu_op = ALU_SUB;
                    else if (f3 == 3'b101) dec.alu_op = ALU_SRA;
                    else                   bad = 1'b1;
                end else if (f7 != '0) begin
                    bad = 1'b1;
                end
            end
            OPC_I: begin
                use_rs1     = 1'b1;
                use_rd      = 1'b1;
                dec.use_imm = 1'b1;
                fmt         = FMT_I;
                dec.alu_op  = alu_from_funct3(f3);
                if (f3 == 3'b001) begin
                    fmt = FMT_SHAMT;
                    bad = (f7 != '0);
                end else if (f3 == 3'b101) begin
                    fmt = FMT_SHAMT;
                    if (f7 == F7_ALT)   dec.alu_op = ALU_SRA;
                    else if (f7 != '0)  bad = 1'b1;
                end
            end
            OPC_LOAD: begin
                use_rs1     = 1'b1;
                use_rd      = 1'b1;
                dec.use_imm = 1'b1;
                dec.is_load = 1'b1;
                dec.funct3  = f3;
                fmt         = FMT_I;
                bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                dec.use_imm  = 1'b1;
                dec.is_store = 1'b1;
                dec.funct3   = f3;
                fmt          = FMT_S;
                bad = (f3 >= 3'b011);
            end
            OPC_BRANCH: begin
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec.alu_op    = ALU_SUB;
                dec.is_branch = 1'b1;
                dec.funct3    = f3;
                fmt           = FMT_B;
                bad = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_JAL: begin
                use_rd      = 1'b1;
                dec.use_imm = 1'b1;
                dec.is_jal  = 1'b1;
                fmt         = FMT_J;
            end
            OPC_JALR: begin
                use_rs1     = 1'b1;
                use_rd      = 1'b1;
                dec.use_imm = 1'b1;
                dec.is_jalr = 1'b1;
                fmt         = FMT_I;
            end
            OPC_LUI: begin
                use_rd      = 1'b1;
                dec.use_imm = 1'b1;
                dec.alu_op  = ALU_PASSB;
                fmt         = FMT_U;
            end
            OPC_AUIPC: begin
                use_rd       = 1'b1;
                dec.use_imm  = 1'b1;
                dec.is_auipc = 1'b1;
                fmt          = FMT_U;
            end
            default: bad = 1'b1;
        endcase

        if ((use_rs1 && reg_bad(rs1)) || (use_rs2 && reg_bad(rs2)) || (use_rd && reg_bad(rd)))
            bad = 1'b1;

        dec.rs1     = use_rs1 ? rs1 : '0;
        dec.rs2     = use_rs2 ? rs2 : '0;
        dec.rd      = use_rd  ? rd  : '0;
        dec.illegal = bad;
        dec.rf_we   = use_rd && (rd != '0) && !bad;
        // Illegal micro-ops still flow in order but must not trigger any unit.
        if (bad) begin
            dec.is_load   = 1'b0;
            dec.is_store  = 1'b0;
            dec.is_branch = 1'b0;
            dec.is_jal    = 1'b0;
            dec.is_jalr   = 1'b0;
            dec.is_auipc  = 1'b0;
        end
    end

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr[31:7]),
        .fmt   (fmt),
        .imm   (dec_imm)
    );

    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state != S_EMPTY);
    assign hs        = out_valid && out_ready;

    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        state_next   = S_ONE;
                        load_main_in = 1'b1;
                    end
                end
                S_ONE: begin
                    if (accept && hs) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_next = S_FULL;
                        load_skid  = 1'b1;
                    end else if (hs) begin
                        state_next = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (hs) begin
                        state_next     = S_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_next = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != S_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_ctrl    <= '0;
            main_imm     <= '0;
            main_pc      <= '0;
            skid_ctrl    <= '0;
            skid_imm     <= '0;
            skid_pc      <= '0;
            decode_count <= '0;
        end else begin
            if (load_main_in) begin
                main_ctrl <= dec;
                main_imm  <= dec_imm;
                main_pc   <= in_pc;
            end else if (load_main_skid) begin
                main_ctrl <= skid_ctrl;
                main_imm  <= skid_imm;
                main_pc   <= skid_pc;
            end
            if (load_skid) begin
                skid_ctrl <= dec;
                skid_imm  <= dec_imm;
                skid_pc   <= in_pc;
            end
            if (hs && !flush)
                decode_count <= decode_count + CNT_W'(1);
        end
    end

    assign out_pc        = main_pc;
    assign out_imm       = main_imm;
    assign out_alu_op    = main_ctrl.alu_op;
    assign out_rs1       = main_ctrl.rs1;
    assign out_rs2       = main_ctrl.rs2;
    assign out_rd        = main_ctrl.rd;
    assign out_use_imm   = main_ctrl.use_imm;
    assign out_rf_we     = main_ctrl.rf_we;
    assign out_is_load   = main_ctrl.is_load;
    assign out_is_store  = main_ctrl.is_store;
    assign out_is_branch = main_ctrl.is_branch;
    assign out_is_jal    = main_ctrl.is_jal;
    assign out_is_jalr   = main_ctrl.is_jalr;
    assign out_is_auipc  = main_ctrl.is_auipc;
    assign out_funct3    = main_ctrl.funct3;
    assign out_illegal   = main_ctrl.illegal;

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Parametrised successor to the single-issue multi-cycle decoder FSM.
- Fully decodes RV32I/RV32E base formats (R, I, load, S, B, U, J, JALR, LUI, AUIPC) into a registered micro-op bundle.
- Sits between fetch and the register-file/ALU/branch stage, with valid/ready handshakes on both sides.
- Two-entry skid buffer sustains one instruction per cycle under backpressure; supports flush and illegal-instruction flagging.

Parameters:
- XLEN, 32, datapath width; immediates and PC are sign-extended or held at this width.
- NREGS, 32, architectural register count (32 = RV32I, 16 = RV32E); wider register indices are illegal.
- CNT_W, 32, width of the retired-decode counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all buffered entries this cycle
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage can accept; registered, depends only on occupancy
- in_instr  in  32  raw instruction word
- in_pc  in  XLEN  PC of in_instr
- out_valid  out  1  micro-op valid
- out_ready  in  1  consumer accepts micro-op
- out_pc  out  XLEN  PC carried with the micro-op
- out_alu_op  out  4  ADD0 SUB1 AND2 OR3 XOR4 SLL5 SLT6 SLTU7 SRA8 SRL9 PASSB10
- out_rs1, out_rs2, out_rd  out  5 each  register indices; forced to 0 when the format does not use them
- out_imm  out  XLEN  sign-extended immediate
- out_use_imm  out  1  ALU operand B is out_imm
- out_rf_we  out  1  writes rd; 0 when rd==0
- out_is_load, out_is_store, out_is_branch, out_is_jal, out_is_jalr, out_is_auipc  out  1 each  class flags
- out_funct3  out  3  passed through for branch, load and store sizing
- out_illegal  out  1  illegal encoding
- decode_count  out  CNT_W  count of micro-ops handed off

Behaviour:
- Reset:
  - All outputs 0, except in_ready=1.
  - Occupancy is EMPTY; decode_count=0.
- Decode:
  - Combinational from in_instr, registered on acceptance (in_valid && in_ready).
  - Latency: 1 cycle from acceptance to out_valid.
- Occupancy FSM:
  - EMPTY -> ONE on accept.
  - ONE -> EMPTY on output handshake with no accept.
  - ONE -> FULL on accept without handshake.
  - ONE stays ONE on simultaneous accept and handshake.
  - FULL -> ONE on handshake.
  - in_ready = (state != FULL), registered.
  - The skid entry is presented only after the main entry drains. Order is strictly preserved; no entry is dropped or duplicated.
- Immediates:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All sign-extended from their top bit to XLEN.
  - Shift-immediate forms set imm = shamt instr[24:20], zero-extended.
- ALU op selection:
  - R-type: funct3 selects the op; funct7 0100000 selects SUB or SRA; any other non-zero funct7 is illegal.
  - I-type: the same funct3 mapping with no SUB. SRAI requires instr[31:25]=0100000; SLLI and SRLI require 0.
  - Load, store, JALR, AUIPC: ADD.
  - LUI: PASSB.
  - Branches: SUB; the comparison itself is downstream.
- Illegal:
  - Illegal cases: unknown opcode, bad funct7, any used register index >= NREGS, branch funct3 010 or 011, load funct3 011/110/111, store funct3 >= 011.
  - An illegal micro-op is still emitted in order, with out_rf_we=0 and all class flags 0.
- Flush:
  - Occupancy -> EMPTY and out_valid=0 next cycle.
  - An instruction presented in the same cycle is not accepted; in_ready=1 next cycle.
  - Flush takes priority over accept and handshake; decode_count is not incremented for a handshake coinciding with flush.
- decode_count:
  - Increments on each output handshake; wraps modulo 2^CNT_W.
  - Reset mid-operation clears it along with all buffered entries.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants (R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - the ALU op enum (values above, shared with the ALU);
  - a format enum;
  - the micro-op struct typedef.
- One natural sub-module, rv_imm_gen: combinational format -> XLEN immediate.
- The decode function and skid buffer stay in rv_decode_stage.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle: out_valid=1, out_alu_op=0, out_imm=0xFFFFFFFF, out_rd=1, out_use_imm=1, out_rf_we=1.
- SUB x3,x1,x2 (0x402081B3) -> out_alu_op=1, rs1=1, rs2=2, rd=3, use_imm=0. Same encoding with funct7=0x01 -> out_illegal=1, out_rf_we=0.
- BEQ x1,x2,-4 (0xFE208EE3) -> out_imm=0xFFFFFFFC, out_is_branch=1, out_rf_we=0, out_rd=0. JAL x1,+2048 (0x001000EF) -> out_imm=0x00000800, out_is_jal=1.
- Backpressure: hold out_ready=0 and offer 3 back-to-back instructions ->
  - in_ready falls after 2 are accepted;
  - releasing out_ready emits all 3 in order on consecutive cycles;
  - decode_count=3.
- NREGS=16: ADD x16,x0,x0 (0x00000833) -> out_illegal=1.
- Flush with FULL occupancy and in_valid=1 -> next cycle out_valid=0, in_ready=1, decode_count unchanged.
